// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a single-port word-wide SRAM. Byte, halfword and word
// accesses use little-endian lane selection, every OKAY data phase carries WAIT_STATES
// wait cycles, and illegal transfers get a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        rst_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned Depth    = 1 << ADDR_WIDTH;
    localparam logic [32:0] MemBytes = 33'(Depth) << 2;
    localparam logic [2:0]  WaitInit = 3'(WAIT_STATES);

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [3:0]              strb_q;
    logic                    write_q;
    logic [31:0]             hrdata_q;
    logic [31:0]             mem_q [Depth];

    logic                    accept;
    logic [31:0]             offset;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    addr_err;
    logic [3:0]              strb;
    logic                    wr_en;
    logic [31:0]             wmask;
    logic [31:0]             wr_word;
    logic [31:0]             rd_word;

    // Burst type, protection, lock and HTRANS[0] play no part in decoding.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Address-phase decode: acceptance, legality check and byte-lane strobes.
    always_comb begin
        accept   = HSEL & HREADY & HTRANS[1];
        offset   = HADDR - BASE_ADDR;
        idx      = offset[ADDR_WIDTH+1:2];
        addr_err = (HADDR < BASE_ADDR) || ({1'b0, offset} >= MemBytes) ||
                   (HSIZE > 3'b010) ||
                   ((HSIZE == 3'b001) && HADDR[0]) ||
                   ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
        strb = 4'b0000;
        case (HSIZE)
            3'b000:  strb = 4'b0001 << HADDR[1:0];
            3'b001:  strb = HADDR[1] ? 4'b1100 : 4'b0011;
            3'b010:  strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
    end

    // Write commit merge, plus read forwarding when a read hits the word being committed.
    always_comb begin
        wr_en   = (state_q == StData) && write_q;
        wmask   = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
        wr_word = (mem_q[idx_q] & ~wmask) | (HWDATA & wmask);
        rd_word = (wr_en && (idx_q == idx)) ? wr_word : mem_q[idx];
    end

    // Next-state logic and bus responses decoded from the current state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (state_q)
            StIdle, StData, StErr2: begin
                if (state_q == StErr2) HRESP = 1'b1;
                if (!accept) begin
                    state_d = StIdle;
                end else if (addr_err) begin
                    state_d = StErr1;
                end else if (WAIT_STATES == 0) begin
                    state_d = StData;
                end else begin
                    state_d = StWait;
                    cnt_d   = WaitInit;
                end
            end
            StWait: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 3'd1) begin
                    state_d = StData;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, wait counter and captured address-phase fields.
    always_ff @(posedge HCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            strb_q   <= 4'b0000;
            write_q  <= 1'b0;
            hrdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= idx;
                strb_q  <= strb;
                write_q <= HWRITE & ~addr_err;
                if (!HWRITE && !addr_err) hrdata_q <= rd_word;
            end
        end
    end

    // SRAM array; contents survive reset, and reset drops any pending write via state_q.
    always_ff @(posedge HCLK) begin
        if (wr_en) mem_q[idx_q] <= wr_word;
    end

    assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with zero wait states at base 0, one with three
// wait states at base 0x1000, directed cases followed by a randomized mix against a
// byte-level memory model.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          which;

    logic        hsel0, hsel1;
    logic        ro0, ro1, rs0, rs1;
    logic [31:0] rd0, rd1;
    logic        hready, hresp;
    logic [31:0] hrdata;

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [2][16];

    always #5 clk = ~clk;

    assign hsel0  = hsel & (which == 0);
    assign hsel1  = hsel & (which == 1);
    assign hready = (which == 1) ? ro1 : ro0;
    assign hresp  = (which == 1) ? rs1 : rs0;
    assign hrdata = (which == 1) ? rd1 : rd0;

    ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .rst_n(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(ro0), .HREADYOUT(ro0),
        .HRESP(rs0), .HRDATA(rd0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000), .WAIT_STATES(3)) u_dut1 (
        .HCLK(clk), .rst_n(rst_n), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(ro1), .HREADYOUT(ro1),
        .HRESP(rs1), .HRDATA(rd1)
    );

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? 32'h1000 : 32'h0;
    endfunction

    function automatic int waits_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic bit illegal(input logic [31:0] a, input logic [2:0] sz,
                                   input logic [31:0] b);
        if (a < b) return 1'b1;
        if (a - b >= 32'd4096) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    // Replace the bytes covered by [a, a + size) with the matching bytes of wd.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] r;
        int lo;
        int n;
        r  = old;
        lo = int'(a % 4);
        n  = 1 << sz;
        for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + n) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
    endtask

    // One non-pipelined transfer; returns at the negedge of its final data cycle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic first_resp, output logic last_resp, output int waits);
        int cyc;
        @(negedge clk);
        hsel   = 1'b1;
        haddr  = addr;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = size;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        haddr      = $urandom;
        hwdata     = wd;
        first_resp = hresp;
        waits      = 0;
        cyc        = 0;
        while (hready !== 1'b1 && cyc < 20) begin
            waits++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 20) begin
            tests++;
            fails++;
            $error("FAIL timeout: observed HREADYOUT %b expected 1", hready);
        end
        rd        = hrdata;
        last_resp = hresp;
    endtask

    initial begin
        logic [31:0] rd, wd, addr, b;
        logic        fr, lr;
        int          wt, w, off, d;
        logic [2:0]  sz;
        bit          wr, bad;

        rst_n  = 1'b0;
        which  = 0;
        hwdata = 32'h0;
        haddr  = 32'h0;
        drive_idle();
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(ro0), 32'h1);
        check("rst_resp0", 32'(rs0), 32'h0);
        check("rst_rdata0", rd0, 32'h0);
        check("rst_ready1", 32'(ro1), 32'h1);
        check("rst_resp1", 32'(rs1), 32'h0);
        check("rst_rdata1", rd1, 32'h0);
        rst_n = 1'b1;

        // Fill the first 16 words of both memories.
        for (int dd = 0; dd < 2; dd++) begin
            which = dd;
            for (int ww = 0; ww < 16; ww++) begin
                wd = $urandom;
                xfer(1'b1, base_of(dd) + 32'(ww * 4), 3'd2, wd, rd, fr, lr, wt);
                mdl[dd][ww] = wd;
            end
        end

        // Back-to-back word write then read of the same word: forwarded data.
        which = 0;
        xfer(1'b1, 32'h10, 3'd2, 32'h0BAD_F00D, rd, fr, lr, wt);
        @(negedge clk);
        hsel = 1'b1; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk);
        @(negedge clk);
        hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("fwd_rdata", hrdata, 32'hDEAD_BEEF);
        check("fwd_resp", 32'(hresp), 32'h0);
        check("fwd_ready", 32'(hready), 32'h1);
        drive_idle();
        mdl[0][4] = 32'hDEAD_BEEF;
        xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, fr, lr, wt);
        check("fwd_readback", rd, 32'hDEAD_BEEF);

        // Sub-word writes over a known word.
        xfer(1'b1, 32'h10, 3'd2, 32'h1122_3344, rd, fr, lr, wt);
        xfer(1'b1, 32'h13, 3'd0, 32'hA55A_5A5A, rd, fr, lr, wt);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, fr, lr, wt);
        check("byte_lane3", rd, 32'hA522_3344);
        xfer(1'b1, 32'h12, 3'd1, 32'h7788_CCDD, rd, fr, lr, wt);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, fr, lr, wt);
        check("half_upper", rd, 32'h7788_3344);
        mdl[0][4] = 32'h7788_3344;

        // Illegal transfers: two-cycle error, memory untouched.
        xfer(1'b1, 32'h01, 3'd1, 32'hFFFF_FFFF, rd, fr, lr, wt);
        check("err_half_first", 32'(fr), 32'h1);
        check("err_half_wait", 32'(wt), 32'h1);
        check("err_half_last", 32'(lr), 32'h1);
        xfer(1'b1, 32'h04, 3'd3, 32'hFFFF_FFFF, rd, fr, lr, wt);
        check("err_size_first", 32'(fr), 32'h1);
        check("err_size_wait", 32'(wt), 32'h1);
        check("err_size_last", 32'(lr), 32'h1);
        xfer(1'b1, 32'h1000, 3'd2, 32'hFFFF_FFFF, rd, fr, lr, wt);
        check("err_range_first", 32'(fr), 32'h1);
        check("err_range_wait", 32'(wt), 32'h1);
        check("err_range_last", 32'(lr), 32'h1);
        xfer(1'b0, 32'h04, 3'd2, 32'h0, rd, fr, lr, wt);
        check("err_rb_w1", rd, mdl[0][1]);
        xfer(1'b0, 32'h00, 3'd2, 32'h0, rd, fr, lr, wt);
        check("err_rb_w0", rd, mdl[0][0]);

        // IDLE, BUSY and unselected NONSEQ: no access, zero-wait OKAY.
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        hwdata = 32'hCAFE_CAFE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("noacc_ready", 32'(hready), 32'h1);
            check("noacc_resp", 32'(hresp), 32'h0);
            check("noacc_rdata", hrdata, mdl[0][0]);
            if (k == 0) htrans = 2'b01;
            if (k == 1) begin htrans = 2'b10; hsel = 1'b0; end
        end
        drive_idle();
        xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, fr, lr, wt);
        check("noacc_rb", rd, mdl[0][4]);

        // Three wait states on the second instance.
        which = 1;
        xfer(1'b0, 32'h1020, 3'd2, 32'h0, rd, fr, lr, wt);
        check("ws3_waits", 32'(wt), 32'h3);
        check("ws3_rdata", rd, mdl[1][8]);
        check("ws3_resp", 32'(lr), 32'h0);
        xfer(1'b1, 32'h1001, 3'd1, 32'h0, rd, fr, lr, wt);
        check("ws3_err_wait", 32'(wt), 32'h1);
        check("ws3_err_resp", 32'(fr & lr), 32'h1);
        xfer(1'b1, 32'h0FFC, 3'd2, 32'h0, rd, fr, lr, wt);
        check("below_base_resp", 32'(lr), 32'h1);

        // Reset during the wait phase of a write abandons it.
        @(negedge clk);
        hsel = 1'b1; haddr = 32'h1030; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        hwdata = ~mdl[1][12];
        check("rstmid_waiting", 32'(hready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_ready", 32'(hready), 32'h1);
        check("rstmid_resp", 32'(hresp), 32'h0);
        check("rstmid_rdata", hrdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h1030, 3'd2, 32'h0, rd, fr, lr, wt);
        check("rstmid_rb", rd, mdl[1][12]);

        // Randomized mix against the model.
        for (int i = 0; i < 80; i++) begin
            d     = i % 2;
            which = d;
            w     = $urandom_range(0, 15);
            off   = $urandom_range(0, 3);
            sz    = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            b     = base_of(d);
            addr  = b + 32'(w * 4 + off);
            if ($urandom_range(0, 9) == 0)
                addr = (d == 1 && $urandom_range(0, 1) == 1) ? 32'(w * 4 + off)
                                                             : addr + 32'h1000;
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            bad = illegal(addr, sz, b);
            xfer(wr, addr, sz, wd, rd, fr, lr, wt);
            check("rnd_resp", 32'(lr), 32'(bad));
            check("rnd_waits", 32'(wt), bad ? 32'h1 : 32'(waits_of(d)));
            if (!bad) begin
                if (wr) mdl[d][w] = merge(mdl[d][w], wd, addr, sz);
                else check("rnd_rdata", rd, mdl[d][w]);
            end
        end

        // Final sweep of both memories.
        for (int dd = 0; dd < 2; dd++) begin
            which = dd;
            for (int ww = 0; ww < 16; ww++) begin
                xfer(1'b0, base_of(dd) + 32'(ww * 4), 3'd2, 32'h0, rd, fr, lr, wt);
                check("sweep", rd, mdl[dd][ww]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
